// File: rtl/store_buffer_fwd.sv
// store_buffer_fwd: in-order store buffer between store commit and the
// data-memory write port. Coalesces byte writes into the youngest queued
// entry and forwards pending bytes to the load unit combinationally.
module store_buffer_fwd #(
    parameter  int ADDR_W = 32,
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 8,
    localparam int BE_W   = DATA_W / 8,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    // store commit side
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    input  logic [BE_W-1:0]   st_be,
    // load forwarding
    input  logic [ADDR_W-1:0] ld_addr,
    output logic [BE_W-1:0]   ld_be,
    output logic [DATA_W-1:0] ld_data,
    output logic              ld_hit,
    // memory write side
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic [BE_W-1:0]   mem_be,
    // occupancy
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full
);

    localparam int OFS   = $clog2(BE_W);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int WA_W  = ADDR_W - OFS;

    // Entry storage: word address, data, byte enables (not reset).
    logic [WA_W-1:0]   ent_addr [DEPTH];
    logic [DATA_W-1:0] ent_data [DEPTH];
    logic [BE_W-1:0]   ent_be   [DEPTH];

    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W-1:0]  tail_m1;
    logic [CNT_W-1:0]  count_q;

    logic [WA_W-1:0]   st_word;
    logic [WA_W-1:0]   ld_word;
    logic              push_fire;
    logic              push_merge;
    logic              push_alloc;
    logic              pop_fire;

    logic [ADDR_W-1:0] head_addr;

    logic [PTR_W-1:0]  fwd_idx;
    logic [BE_W-1:0]   fwd_be;
    logic [DATA_W-1:0] fwd_data;

    // Status is derived from the registered count only.
    assign count    = count_q;
    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign st_ready = !full;

    assign st_word  = st_addr[ADDR_W-1:OFS];
    assign ld_word  = ld_addr[ADDR_W-1:OFS];
    assign tail_m1  = tail - PTR_W'(1);

    // A store with no enabled bytes completes the handshake but stores nothing.
    // Merging needs at least two entries so the head (possibly being drained
    // this very cycle) is never modified.
    assign push_fire  = st_valid && st_ready && (st_be != '0);
    assign push_merge = push_fire && (count_q >= CNT_W'(2))
                        && (ent_addr[tail_m1] == st_word);
    assign push_alloc = push_fire && !push_merge;
    assign pop_fire   = !empty && mem_ready;

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (push_alloc)
                tail <= tail + PTR_W'(1);
            if (pop_fire)
                head <= head + PTR_W'(1);
            if (push_alloc && !pop_fire)
                count_q <= count_q + CNT_W'(1);
            else if (!push_alloc && pop_fire)
                count_q <= count_q - CNT_W'(1);
        end
    end

    // Entry write: allocate a new entry at tail or merge lanes into tail-1.
    always_ff @(posedge clk) begin
        if (push_alloc) begin
            ent_addr[tail] <= st_word;
            ent_data[tail] <= st_data;
            ent_be[tail]   <= st_be;
        end else if (push_merge) begin
            for (int unsigned b = 0; b < BE_W; b++) begin
                if (st_be[b])
                    ent_data[tail_m1][8*b +: 8] <= st_data[8*b +: 8];
            end
            ent_be[tail_m1] <= ent_be[tail_m1] | st_be;
        end
    end

    assign head_addr = ADDR_W'(ent_addr[head]) << OFS;

    // Head entry presentation; all zero while the buffer is empty.
    always_comb begin
        mem_valid = !empty;
        mem_addr  = '0;
        mem_data  = '0;
        mem_be    = '0;
        if (!empty) begin
            mem_addr = head_addr;
            mem_data = ent_data[head];
            mem_be   = ent_be[head];
        end
    end

    // Forwarding: walk entries oldest to youngest so younger bytes win per lane.
    always_comb begin
        fwd_idx  = '0;
        fwd_be   = '0;
        fwd_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            fwd_idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (ent_addr[fwd_idx] == ld_word)) begin
                for (int unsigned b = 0; b < BE_W; b++) begin
                    if (ent_be[fwd_idx][b]) begin
                        fwd_be[b]          = 1'b1;
                        fwd_data[8*b +: 8] = ent_data[fwd_idx][8*b +: 8];
                    end
                end
            end
        end
    end

    assign ld_be   = fwd_be;
    assign ld_data = fwd_data;
    assign ld_hit  = |fwd_be;

endmodule

// File: tb/tb_store_buffer_fwd.sv
// tb_store_buffer_fwd: directed vectors with hand-computed expectations for
// the store buffer (default 32-bit address/data, 8 entries).
module tb_store_buffer_fwd;

    logic        clk;
    logic        reset;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [3:0]  st_be;
    logic [31:0] ld_addr;
    logic [3:0]  ld_be;
    logic [31:0] ld_data;
    logic        ld_hit;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [3:0]  mem_be;
    logic [3:0]  count;
    logic        empty;
    logic        full;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    wr_t writes[$];
    wr_t exp_q[$];

    int n_vec;
    int n_bad;

    store_buffer_fwd #(.ADDR_W(32), .DATA_W(32), .DEPTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_be     (st_be),
        .ld_addr   (ld_addr),
        .ld_be     (ld_be),
        .ld_data   (ld_data),
        .ld_hit    (ld_hit),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_be    (mem_be),
        .count     (count),
        .empty     (empty),
        .full      (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every memory write handshake, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_valid === 1'b1 && mem_ready === 1'b1)
            writes.push_back('{mem_addr, mem_data, mem_be});
    end

    // Hard stop so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        st_addr  = a;
        st_data  = d;
        st_be    = be;
        st_valid = 1'b1;
        tick();
        st_valid = 1'b0;
    endtask

    task automatic expect_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        exp_q.push_back('{a, d, be});
    endtask

    task automatic drain();
        mem_ready = 1'b1;
        for (int c = 0; c < 64 && !empty; c++)
            tick();
        check("drain_empty", 64'(empty), 64'(1));
        mem_ready = 1'b0;
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_nwr"}, 64'(writes.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < writes.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), 64'(writes[i].addr), 64'(exp_q[i].addr));
            check($sformatf("%s_data%0d", tag, i), 64'(writes[i].data), 64'(exp_q[i].data));
            check($sformatf("%s_be%0d", tag, i),   64'(writes[i].be),   64'(exp_q[i].be));
        end
        writes.delete();
        exp_q.delete();
    endtask

    initial begin
        int k;
        logic acc;

        n_vec     = 0;
        n_bad     = 0;
        reset     = 1'b1;
        st_valid  = 1'b0;
        st_addr   = '0;
        st_data   = '0;
        st_be     = '0;
        ld_addr   = 32'h100;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;

        // reset values
        check("rst_count",     64'(count),     64'(0));
        check("rst_empty",     64'(empty),     64'(1));
        check("rst_full",      64'(full),      64'(0));
        check("rst_st_ready",  64'(st_ready),  64'(1));
        check("rst_mem_valid", 64'(mem_valid), 64'(0));
        check("rst_mem_addr",  64'(mem_addr),  64'(0));
        check("rst_mem_data",  64'(mem_data),  64'(0));
        check("rst_mem_be",    64'(mem_be),    64'(0));
        check("rst_ld_hit",    64'(ld_hit),    64'(0));
        check("rst_ld_be",     64'(ld_be),     64'(0));
        check("rst_ld_data",   64'(ld_data),   64'(0));

        // fill to capacity, refuse a 9th, then drain in order
        for (int i = 0; i < 8; i++) begin
            push(32'h100 + 32'(4 * i), 32'(i), 4'hF);
            expect_wr(32'h100 + 32'(4 * i), 32'(i), 4'hF);
            if (i == 0) begin
                check("t1_lat_valid", 64'(mem_valid), 64'(1));
                check("t1_lat_addr",  64'(mem_addr),  64'h100);
            end
        end
        check("t1_count",    64'(count),    64'(8));
        check("t1_full",     64'(full),     64'(1));
        check("t1_st_ready", 64'(st_ready), 64'(0));
        st_addr  = 32'h120;
        st_data  = 32'd8;
        st_be    = 4'hF;
        st_valid = 1'b1;
        tick();
        check("t1_no_9th",   64'(count),    64'(8));
        check("t1_hold_addr", 64'(mem_addr), 64'h100);
        check("t1_hold_data", 64'(mem_data), 64'(0));
        mem_ready = 1'b1;
        tick();
        check("t1_full_pop_no_push", 64'(count), 64'(7));
        st_valid = 1'b0;
        drain();
        check_writes("t1");
        check("t1_mem_addr0", 64'(mem_addr), 64'(0));

        // merge into youngest entry
        push(32'h200, 32'h11223344, 4'hF);
        push(32'h204, 32'h000000AA, 4'hF);
        push(32'h204, 32'h0000BB00, 4'h2);
        check("t2_count", 64'(count), 64'(2));
        expect_wr(32'h200, 32'h11223344, 4'hF);
        expect_wr(32'h204, 32'h0000BBAA, 4'hF);
        drain();
        check_writes("t2");

        // count==1: no merge into head
        push(32'h300, 32'h00000055, 4'h1);
        push(32'h300, 32'h00006600, 4'h2);
        check("t3_count", 64'(count), 64'(2));
        ld_addr = 32'h300;
        #1;
        check("t3_ld_be",   64'(ld_be),   64'h3);
        check("t3_ld_data", 64'(ld_data), 64'h6655);
        expect_wr(32'h300, 32'h00000055, 4'h1);
        expect_wr(32'h300, 32'h00006600, 4'h2);
        drain();
        check_writes("t3");

        // forwarding across two entries of the same word, and a miss
        push(32'h400, 32'h11111111, 4'hF);
        push(32'h400, 32'h00002200, 4'h2);
        ld_addr = 32'h402;
        #1;
        check("t4_ld_be",   64'(ld_be),   64'hF);
        check("t4_ld_data", 64'(ld_data), 64'h11112211);
        check("t4_ld_hit",  64'(ld_hit),  64'(1));
        ld_addr = 32'h500;
        #1;
        check("t4_miss_hit",  64'(ld_hit),  64'(0));
        check("t4_miss_be",   64'(ld_be),   64'(0));
        check("t4_miss_data", 64'(ld_data), 64'(0));
        ld_addr = 32'h400;
        mem_ready = 1'b1;
        #1;
        check("t4_pop_cycle_fwd", 64'(ld_data), 64'h11112211);
        mem_ready = 1'b0;
        expect_wr(32'h400, 32'h11111111, 4'hF);
        expect_wr(32'h400, 32'h00002200, 4'h2);
        drain();
        check_writes("t4");

        // continuous traffic, mem_ready toggling, several pointer wraps
        k = 0;
        for (int c = 0; c < 300 && k < 30; c++) begin
            st_addr  = 32'h1000 + 32'(4 * k);
            st_data  = 32'(k);
            st_be    = 4'hF;
            st_valid = 1'b1;
            acc      = st_ready;
            tick();
            if (acc) begin
                expect_wr(32'h1000 + 32'(4 * k), 32'(k), 4'hF);
                k++;
            end
            mem_ready = ~mem_ready;
        end
        st_valid = 1'b0;
        check("t5_pushed", 64'(k), 64'(30));
        drain();
        check_writes("t5");

        // one in, one out per cycle
        mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push(32'h2000 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF);
            expect_wr(32'h2000 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF);
            check($sformatf("t6_count%0d", i), 64'(count), 64'(1));
        end
        drain();
        check_writes("t6");

        // reset mid-operation
        for (int i = 0; i < 5; i++)
            push(32'h3000 + 32'(4 * i), 32'(i), 4'hF);
        check("t7_count5",    64'(count),     64'(5));
        check("t7_mem_valid", 64'(mem_valid), 64'(1));
        reset = 1'b1;
        tick();
        check("t7_rst_valid", 64'(mem_valid), 64'(0));
        check("t7_rst_count", 64'(count),     64'(0));
        check("t7_rst_ready", 64'(st_ready),  64'(1));
        reset     = 1'b0;
        mem_ready = 1'b1;
        writes.delete();
        repeat (5) tick();
        check("t7_no_writes", 64'(writes.size()), 64'(0));
        check("t7_idle_valid", 64'(mem_valid), 64'(0));
        push(32'h600, 32'h77, 4'hF);
        check("t7_new_valid", 64'(mem_valid), 64'(1));
        expect_wr(32'h600, 32'h77, 4'hF);
        tick();
        mem_ready = 1'b0;
        check_writes("t7");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
